gemm_seq: RTL and testbench

Sequencer that drives the combinational `gemm_op` datapath. It accepts one GEMM command: iteration count, per-buffer base addresses and strides. For each iteration it reads an input vector, a weight tile and an accumulator vector from the on-chip scratchpads, then presents them to `gemm_op`. It writes the result vector back to the accumulator scratchpad through a 4-stage pipeline, at up to one iteration per cycle.

---
 rtl/gemm_pkg.sv | 21 ++
 rtl/gemm_seq_agu.sv | 49 ++++
 rtl/gemm_seq.sv | 187 ++++++++++++++++++
 tb/tb_gemm_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared widths, derived tensor widths and sequencer state encoding
// for the gemm_seq sequencer and its address generators.
package gemm_pkg;

    localparam int INP_WIDTH = 8;
    localparam int WGT_WIDTH = 8;
    localparam int ACC_WIDTH = 32;
    localparam int BLOCK     = 16;

    localparam int INP_TENSOR_W = INP_WIDTH * BLOCK;
    localparam int WGT_TENSOR_W = WGT_WIDTH * BLOCK * BLOCK;
    localparam int ACC_TENSOR_W = ACC_WIDTH * BLOCK;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/gemm_seq_agu.sv
// gemm_seq_agu: running base + k*stride address generator (adder only).
// addr shows the address of the next issue; on load it is the new base.
module gemm_seq_agu #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] addr_r;
    logic [AW-1:0] stride_r;
    logic [AW-1:0] stride_s;
    logic [AW-1:0] next_s;

    // Select current address/stride and form the stepped address
    always_comb begin
        if (load) begin
            addr     = base;
            stride_s = stride;
        end else begin
            addr     = addr_r;
            stride_s = stride_r;
        end
        if (step) begin
            next_s = addr + stride_s;
        end else begin
            next_s = addr;
        end
    end

    // Running address and latched stride
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r   <= {AW{1'b0}};
            stride_r <= {AW{1'b0}};
        end else begin
            addr_r <= next_s;
            if (load) begin
                stride_r <= stride;
            end
        end
    end

endmodule

// File: rtl/gemm_seq.sv
// gemm_seq: sequences one GEMM command through a read/operand/write pipeline
// around an external gemm_op. Define GEMM_SEQ_HAZARD_EN to build the acc-address interlock.
module gemm_seq #(
    parameter int INP_WIDTH = gemm_pkg::INP_WIDTH,
    parameter int WGT_WIDTH = gemm_pkg::WGT_WIDTH,
    parameter int ACC_WIDTH = gemm_pkg::ACC_WIDTH,
    parameter int BLOCK     = gemm_pkg::BLOCK,
    parameter int INP_AW    = 11,
    parameter int WGT_AW    = 10,
    parameter int ACC_AW    = 11,
    parameter int CNT_W     = 14
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [CNT_W-1:0]                   cmd_iters,
    input  logic [INP_AW-1:0]                  cmd_inp_base,
    input  logic [INP_AW-1:0]                  cmd_inp_stride,
    input  logic [WGT_AW-1:0]                  cmd_wgt_base,
    input  logic [WGT_AW-1:0]                  cmd_wgt_stride,
    input  logic [ACC_AW-1:0]                  cmd_acc_base,
    input  logic [ACC_AW-1:0]                  cmd_acc_stride,
    input  logic                               cmd_reset_acc,
    output logic                               inp_rd_en,
    output logic [INP_AW-1:0]                  inp_rd_addr,
    input  logic [INP_WIDTH*BLOCK-1:0]         inp_rd_data,
    output logic                               wgt_rd_en,
    output logic [WGT_AW-1:0]                  wgt_rd_addr,
    input  logic [WGT_WIDTH*BLOCK*BLOCK-1:0]   wgt_rd_data,
    output logic                               acc_rd_en,
    output logic [ACC_AW-1:0]                  acc_rd_addr,
    input  logic [ACC_WIDTH*BLOCK-1:0]         acc_rd_data,
    output logic [INP_WIDTH*BLOCK-1:0]         gemm_i_tensor,
    output logic [WGT_WIDTH*BLOCK*BLOCK-1:0]   gemm_w_tensor,
    output logic [ACC_WIDTH*BLOCK-1:0]         gemm_a_tensor,
    input  logic [ACC_WIDTH*BLOCK-1:0]         gemm_o_tensor,
    output logic                               acc_wr_en,
    output logic [ACC_AW-1:0]                  acc_wr_addr,
    output logic [ACC_WIDTH*BLOCK-1:0]         acc_wr_data,
    output logic                               busy,
    output logic                               done
);
    import gemm_pkg::*;

    localparam int IT_W = INP_WIDTH * BLOCK;
    localparam int WT_W = WGT_WIDTH * BLOCK * BLOCK;
    localparam int AT_W = ACC_WIDTH * BLOCK;

    state_e              state_r, state_s;
    logic [CNT_W-1:0]    rem_r;
    logic                reset_acc_r, reset_acc_s;
    logic                fire_s, issue_s, last_s, hazard_s;
    logic                iss_v_r, rsp_v_r, opd_v_r;
    logic [ACC_AW-1:0]   rsp_addr_r, opd_addr_r;
    logic [INP_AW-1:0]   inp_addr_s;
    logic [WGT_AW-1:0]   wgt_addr_s;
    logic [ACC_AW-1:0]   acc_addr_s;

    assign fire_s    = cmd_valid && (state_r == IDLE);
    assign inp_rd_en = iss_v_r;
    assign wgt_rd_en = iss_v_r;

    gemm_seq_agu #(.AW(INP_AW)) u_inp_agu (.clk(clk), .rst_n(rst_n), .load(fire_s), .step(issue_s),
        .base(cmd_inp_base), .stride(cmd_inp_stride), .addr(inp_addr_s));
    gemm_seq_agu #(.AW(WGT_AW)) u_wgt_agu (.clk(clk), .rst_n(rst_n), .load(fire_s), .step(issue_s),
        .base(cmd_wgt_base), .stride(cmd_wgt_stride), .addr(wgt_addr_s));
    gemm_seq_agu #(.AW(ACC_AW)) u_acc_agu (.clk(clk), .rst_n(rst_n), .load(fire_s), .step(issue_s),
        .base(cmd_acc_base), .stride(cmd_acc_stride), .addr(acc_addr_s));

`ifdef GEMM_SEQ_HAZARD_EN
    // Hold issue while an older iteration for this acc address has not yet been written
    always_comb begin
        hazard_s = (iss_v_r && (acc_rd_addr == acc_addr_s)) ||
                   (rsp_v_r && (rsp_addr_r  == acc_addr_s)) ||
                   (opd_v_r && (opd_addr_r  == acc_addr_s));
    end
`else
    assign hazard_s = 1'b0;
`endif

    // Next-state and issue decision; iteration 0 issues straight off the handshake
    always_comb begin
        state_s     = state_r;
        issue_s     = 1'b0;
        last_s      = 1'b0;
        reset_acc_s = fire_s ? cmd_reset_acc : reset_acc_r;
        case (state_r)
            IDLE: begin
                if (!cmd_valid) begin
                    state_s = IDLE;
                end else if (cmd_iters == CNT_W'(0)) begin
                    state_s = DRAIN;
                end else begin
                    issue_s = 1'b1;
                    last_s  = (cmd_iters == CNT_W'(1));
                    state_s = last_s ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (hazard_s) begin
                    state_s = RUN;
                end else begin
                    issue_s = 1'b1;
                    last_s  = (rem_r == CNT_W'(1));
                    state_s = last_s ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (!iss_v_r && !rsp_v_r && !opd_v_r) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state, command latches and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rem_r       <= {CNT_W{1'b0}};
            reset_acc_r <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_s;
            reset_acc_r <= reset_acc_s;
            cmd_ready   <= (state_s == IDLE);
            busy        <= (state_s != IDLE);
            done        <= (state_s == DONE);
            if (fire_s) begin
                rem_r <= cmd_iters - CNT_W'(1);
            end else if (issue_s) begin
                rem_r <= rem_r - CNT_W'(1);
            end
        end
    end

    // Issue, response, operand and write stages, each with a valid bit and acc address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_v_r       <= 1'b0;
            acc_rd_en     <= 1'b0;
            inp_rd_addr   <= {INP_AW{1'b0}};
            wgt_rd_addr   <= {WGT_AW{1'b0}};
            acc_rd_addr   <= {ACC_AW{1'b0}};
            rsp_v_r       <= 1'b0;
            rsp_addr_r    <= {ACC_AW{1'b0}};
            opd_v_r       <= 1'b0;
            opd_addr_r    <= {ACC_AW{1'b0}};
            gemm_i_tensor <= {IT_W{1'b0}};
            gemm_w_tensor <= {WT_W{1'b0}};
            gemm_a_tensor <= {AT_W{1'b0}};
            acc_wr_en     <= 1'b0;
            acc_wr_addr   <= {ACC_AW{1'b0}};
            acc_wr_data   <= {AT_W{1'b0}};
        end else begin
            iss_v_r   <= issue_s;
            acc_rd_en <= issue_s && !reset_acc_s;
            if (issue_s) begin
                inp_rd_addr <= inp_addr_s;
                wgt_rd_addr <= wgt_addr_s;
                acc_rd_addr <= acc_addr_s;
            end
            rsp_v_r    <= iss_v_r;
            rsp_addr_r <= acc_rd_addr;
            opd_v_r    <= rsp_v_r;
            if (rsp_v_r) begin
                gemm_i_tensor <= inp_rd_data;
                gemm_w_tensor <= wgt_rd_data;
                gemm_a_tensor <= reset_acc_r ? {AT_W{1'b0}} : acc_rd_data;
                opd_addr_r    <= rsp_addr_r;
            end
            acc_wr_en <= opd_v_r;
            if (opd_v_r) begin
                acc_wr_addr <= opd_addr_r;
                acc_wr_data <= gemm_o_tensor;
            end
        end
    end

endmodule

// File: tb/tb_gemm_seq.sv
// tb_gemm_seq: directed self-checking bench for gemm_seq with scratchpad and
// gemm_op behavioural models; cycle numbers count the command cycle as c.
module tb_gemm_seq;

    localparam int IT = 128;
    localparam int WT = 2048;
    localparam int AT = 512;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [13:0]    cmd_iters = 14'd0;
    logic [10:0]    cmd_inp_base = 11'd0, cmd_inp_stride = 11'd0;
    logic [9:0]     cmd_wgt_base = 10'd0, cmd_wgt_stride = 10'd0;
    logic [10:0]    cmd_acc_base = 11'd0, cmd_acc_stride = 11'd0;
    logic           cmd_reset_acc = 1'b0;
    logic           inp_rd_en, wgt_rd_en, acc_rd_en, acc_wr_en, busy, done;
    logic [10:0]    inp_rd_addr, acc_rd_addr, acc_wr_addr;
    logic [9:0]     wgt_rd_addr;
    logic [IT-1:0]  inp_rd_data, gemm_i_tensor;
    logic [WT-1:0]  wgt_rd_data, gemm_w_tensor;
    logic [AT-1:0]  acc_rd_data, acc_q, gemm_a_tensor, gemm_o_tensor, acc_wr_data;

    logic           init_req = 1'b0;
    logic           force_dead = 1'b0;
    logic [IT-1:0]  inp_mem [16];
    logic [WT-1:0]  wgt_mem [16];
    logic [AT-1:0]  acc_mem [16];

    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;
    int             acc_rd_cnt = 0;
    int             mem_cnt = 0;
    int             wr_cyc [$];
    logic [10:0]    wr_addr_q [$];
    logic [AT-1:0]  wr_data_q [$];
    int             done_cyc [$];

    gemm_seq dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_iters(cmd_iters), .cmd_inp_base(cmd_inp_base), .cmd_inp_stride(cmd_inp_stride),
        .cmd_wgt_base(cmd_wgt_base), .cmd_wgt_stride(cmd_wgt_stride),
        .cmd_acc_base(cmd_acc_base), .cmd_acc_stride(cmd_acc_stride), .cmd_reset_acc(cmd_reset_acc),
        .inp_rd_en(inp_rd_en), .inp_rd_addr(inp_rd_addr), .inp_rd_data(inp_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
        .gemm_i_tensor(gemm_i_tensor), .gemm_w_tensor(gemm_w_tensor), .gemm_a_tensor(gemm_a_tensor),
        .gemm_o_tensor(gemm_o_tensor), .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
        .acc_wr_data(acc_wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // gemm_op reference: o[j] = a[j] + sum_k w[j][k] * i[k], signed 8-bit elements
    function automatic logic [AT-1:0] gemm_model(input logic [IT-1:0] i, input logic [WT-1:0] w,
                                                  input logic [AT-1:0] a);
        logic [AT-1:0]      o;
        logic signed [31:0] s;
        for (int j = 0; j < 16; j++) begin
            s = $signed(a[j*32 +: 32]);
            for (int k = 0; k < 16; k++) begin
                s = s + $signed(w[(j*16+k)*8 +: 8]) * $signed(i[k*8 +: 8]);
            end
            o[j*32 +: 32] = s;
        end
        return o;
    endfunction

    assign gemm_o_tensor = gemm_model(gemm_i_tensor, gemm_w_tensor, gemm_a_tensor);
    assign acc_rd_data   = force_dead ? {16{32'hDEADBEEF}} : acc_q;

    // Scratchpads: inp[k] elements = k+1, wgt elements = 2, acc[k] elements = 100*k
    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 16; k++) begin
                inp_mem[k] <= {16{8'(k + 1)}};
                wgt_mem[k] <= {256{8'd2}};
                acc_mem[k] <= {16{32'(100 * k)}};
            end
        end else if (acc_wr_en) begin
            acc_mem[acc_wr_addr[3:0]] <= acc_wr_data;
        end
        if (inp_rd_en) inp_rd_data <= inp_mem[inp_rd_addr[3:0]];
        if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr[3:0]];
        if (acc_rd_en) acc_q <= acc_mem[acc_rd_addr[3:0]];
    end

    always @(negedge clk) begin
        if (acc_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_addr_q.push_back(acc_wr_addr);
            wr_data_q.push_back(acc_wr_data);
        end
        if (done) done_cyc.push_back(cyc);
        if (acc_rd_en) acc_rd_cnt++;
        if (inp_rd_en || wgt_rd_en || acc_rd_en || acc_wr_en) mem_cnt++;
    end

    task automatic chk(input string tag, input logic [AT-1:0] obs, input logic [AT-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic init_mem();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    task automatic send(input int n, input int ib, input int is, input int wb, input int ws,
                        input int ab, input int ast, input logic ra, output int c);
        @(negedge clk);
        chk("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_iters      = 14'(n);
        cmd_inp_base   = 11'(ib);
        cmd_inp_stride = 11'(is);
        cmd_wgt_base   = 10'(wb);
        cmd_wgt_stride = 10'(ws);
        cmd_acc_base   = 11'(ab);
        cmd_acc_stride = 11'(ast);
        cmd_reset_acc  = ra;
        cmd_valid      = 1'b1;
        c              = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, output int dc);
        int t = 0;
        while (done_cyc.size() == d0 && t < 80) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 512'(done_cyc.size() > d0), 1);
        dc = (done_cyc.size() > d0) ? done_cyc[d0] : -1;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input int idx, input int ec, input int ea, input logic [31:0] ee);
        if (wr_cyc.size() > idx) begin
            chk({tag, "_cycle"}, wr_cyc[idx], ec);
            chk({tag, "_addr"}, wr_addr_q[idx], ea);
            chk({tag, "_data"}, wr_data_q[idx], {16{ee}});
        end else begin
            chk({tag, "_present"}, 0, 1);
        end
    endtask

    initial begin
        int c, dc, w0, d0, r0, m0;
        int e1 [4] = '{32, 164, 296, 428};

        init_mem();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_en", {inp_rd_en, wgt_rd_en, acc_rd_en, acc_wr_en}, 0);
        chk("rst_addr", {inp_rd_addr, wgt_rd_addr, acc_rd_addr, acc_wr_addr}, 0);
        chk("rst_operands", {gemm_i_tensor, gemm_a_tensor}, 0);
        chk("rst_wgt_operand", 512'(|gemm_w_tensor), 0);
        chk("rst_wr_data", acc_wr_data, 0);

        // N=4, unit strides
        init_mem();
        w0 = wr_cyc.size(); d0 = done_cyc.size();
        send(4, 0, 1, 0, 1, 0, 1, 1'b0, c);
        wait_done(d0, dc);
        chk("n4_write_count", wr_cyc.size() - w0, 4);
        for (int k = 0; k < 4; k++) chk_wr($sformatf("n4_k%0d", k), w0 + k, c + 4 + k, k, 32'(e1[k]));
        chk("n4_done_cycle", dc, c + 8);

`ifdef GEMM_SEQ_HAZARD_EN
        // N=3 on one acc address: interlock spaces writes 4 cycles apart
        init_mem();
        w0 = wr_cyc.size(); d0 = done_cyc.size();
        send(3, 0, 1, 0, 1, 5, 0, 1'b0, c);
        wait_done(d0, dc);
        chk("hz_write_count", wr_cyc.size() - w0, 3);
        chk_wr("hz_k0", w0 + 0, c + 4, 5, 32'd532);
        chk_wr("hz_k1", w0 + 1, c + 8, 5, 32'd596);
        chk_wr("hz_k2", w0 + 2, c + 12, 5, 32'd692);
        chk("hz_done_cycle", dc, c + 13);
`else
        // N=3, acc stride 2 from base 1
        init_mem();
        w0 = wr_cyc.size(); d0 = done_cyc.size();
        send(3, 0, 1, 0, 1, 1, 2, 1'b0, c);
        wait_done(d0, dc);
        chk("st2_write_count", wr_cyc.size() - w0, 3);
        chk_wr("st2_k0", w0 + 0, c + 4, 1, 32'd132);
        chk_wr("st2_k1", w0 + 1, c + 5, 3, 32'd364);
        chk_wr("st2_k2", w0 + 2, c + 6, 5, 32'd596);
        chk("st2_done_cycle", dc, c + 7);
`endif

        // N=2 with reset_acc while the acc port returns garbage
        init_mem();
        force_dead = 1'b1;
        w0 = wr_cyc.size(); d0 = done_cyc.size(); r0 = acc_rd_cnt;
        send(2, 4, 1, 0, 1, 2, 1, 1'b1, c);
        wait_done(d0, dc);
        force_dead = 1'b0;
        chk("ra_acc_rd_en_count", acc_rd_cnt - r0, 0);
        chk("ra_write_count", wr_cyc.size() - w0, 2);
        chk_wr("ra_k0", w0 + 0, c + 4, 2, 32'd160);
        chk_wr("ra_k1", w0 + 1, c + 5, 3, 32'd192);
        chk("ra_done_cycle", dc, c + 6);

        // N=0: no memory traffic, done two cycles after the command
        m0 = mem_cnt;
        send(0, 0, 1, 0, 1, 0, 1, 1'b0, c);
        @(negedge clk);
        chk("n0_c1_busy_done", {busy, done}, 2'b10);
        @(negedge clk);
        chk("n0_c2_busy_done", {busy, done}, 2'b11);
        @(negedge clk);
        chk("n0_c3_busy_done", {busy, done}, 2'b00);
        chk("n0_mem_events", mem_cnt - m0, 0);

        // Reset during cycle c+5 of an N=8 run
        init_mem();
        w0 = wr_cyc.size();
        send(8, 0, 1, 0, 1, 0, 1, 1'b0, c);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        repeat (12) @(negedge clk);
        chk("rst_mid_write_count", wr_cyc.size() - w0, 2);
        if (wr_cyc.size() > w0 + 1) chk("rst_mid_last_write_cycle", wr_cyc[w0 + 1], c + 5);

        // Next command after the reset runs normally
        init_mem();
        w0 = wr_cyc.size(); d0 = done_cyc.size();
        send(2, 0, 1, 0, 1, 8, 1, 1'b0, c);
        wait_done(d0, dc);
        chk("post_write_count", wr_cyc.size() - w0, 2);
        chk_wr("post_k0", w0 + 0, c + 4, 8, 32'd832);
        chk_wr("post_k1", w0 + 1, c + 5, 9, 32'd964);
        chk("post_done_cycle", dc, c + 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
